// File: rtl/datapath2_pkg.sv
// Shared constants and types for the pipelined register-file add/sub datapath.
// Operand-source and operation encodings, plus the registered flag bundle.
package datapath2_pkg;

    localparam logic ALUSRC_REG = 1'b0;
    localparam logic ALUSRC_IMM = 1'b1;
    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } flags_t;

    localparam flags_t FLAGS_CLEAR = '{cout: 1'b0, overflow: 1'b0, zero: 1'b0};

endpackage

// File: rtl/datapath2_if.sv
// Issue/result bundle of datapath2: operation request with valid/ready handshake
// on the issuing side, registered result and flags on the return side.
interface datapath2_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    parameter int IMM_W = 16
);
    localparam int AW = $clog2(NREGS);

    logic             i_Valid;
    logic             o_Ready;
    logic             i_ALUSrc;
    logic             i_AddSub;
    logic             i_WE;
    logic [AW-1:0]    i_RA0;
    logic [AW-1:0]    i_RA1;
    logic [AW-1:0]    i_WA;
    logic [IMM_W-1:0] i_Im;
    logic             o_Valid;
    logic [WIDTH-1:0] o_ALUout;
    logic             o_Cout;
    logic             o_Overflow;
    logic             o_Zero;

    modport master (
        output i_Valid, i_ALUSrc, i_AddSub, i_WE, i_RA0, i_RA1, i_WA, i_Im,
        input  o_Ready, o_Valid, o_ALUout, o_Cout, o_Overflow, o_Zero
    );

    modport slave (
        input  i_Valid, i_ALUSrc, i_AddSub, i_WE, i_RA0, i_RA1, i_WA, i_Im,
        output o_Ready, o_Valid, o_ALUout, o_Cout, o_Overflow, o_Zero
    );
endinterface

// File: rtl/datapath2_regfile.sv
// regfile_p: register file with one write port and two combinational read ports.
// Entry 0 is hardwired to zero; writes addressed to it are dropped.
module regfile_p #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(NREGS)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(NREGS)-1:0]   ra0,
    input  logic [$clog2(NREGS)-1:0]   ra1,
    output logic [WIDTH-1:0]           rd0,
    output logic [WIDTH-1:0]           rd1
);
    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Next-state of every entry: the addressed nonzero entry takes the write data.
    always_comb begin
        regs_d[0] = {WIDTH{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            regs_d[i] = (we && (waddr == AW'(i))) ? wdata : regs_q[i];
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: {WIDTH{1'b0}}};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports.
    always_comb begin
        rd0 = (ra0 == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_q[ra0];
        rd1 = (ra1 == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_q[ra1];
    end

endmodule

// File: rtl/datapath2.sv
// datapath2: two-stage register-file add/sub datapath (issue -> EX -> result).
// Define DATAPATH2_FWD_EN to forward the EX result instead of stalling one cycle.
import datapath2_pkg::*;

module datapath2 #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    parameter int IMM_W = 16
) (
    input  logic      i_CLK,
    input  logic      i_RST,
    datapath2_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] rd0_s, rd1_s, imm_ext_s, src_a_s, reg_b_s, src_b_s;
    logic [WIDTH-1:0] addend_s, result_s;
    logic [WIDTH:0]   sum_s;
    flags_t           flags_s;
    logic             ex_wr_s, haz_a_s, haz_b_s, ready_s, issue_s;

    logic             ex_valid_q, ex_valid_d, ex_sub_q, ex_sub_d, ex_we_q, ex_we_d;
    logic [WIDTH-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [AW-1:0]    ex_wa_q, ex_wa_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    flags_t           flags_q, flags_d;

    regfile_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk   (i_CLK),
        .rst   (i_RST),
        .we    (ex_wr_s),
        .waddr (ex_wa_q),
        .wdata (result_s),
        .ra0   (bus.i_RA0),
        .ra1   (bus.i_RA1),
        .rd0   (rd0_s),
        .rd1   (rd1_s)
    );

    // EX-stage ALU; subtraction is A + ~B + 1 so carry-out means "no borrow".
    always_comb begin
        addend_s         = (ex_sub_q == OP_SUB) ? ~ex_b_q : ex_b_q;
        sum_s            = {1'b0, ex_a_q} + {1'b0, addend_s} + {{WIDTH{1'b0}}, ex_sub_q};
        result_s         = sum_s[WIDTH-1:0];
        flags_s.cout     = sum_s[WIDTH];
        flags_s.overflow = (ex_a_q[WIDTH-1] == addend_s[WIDTH-1]) &&
                           (result_s[WIDTH-1] != ex_a_q[WIDTH-1]);
        flags_s.zero     = (result_s == {WIDTH{1'b0}});
    end

    // Hazard detection against the in-flight write, and operand selection.
    always_comb begin
        ex_wr_s   = ex_valid_q && ex_we_q && (ex_wa_q != {AW{1'b0}});
        haz_a_s   = ex_wr_s && (bus.i_RA0 == ex_wa_q);
        haz_b_s   = ex_wr_s && (bus.i_ALUSrc == ALUSRC_REG) && (bus.i_RA1 == ex_wa_q);
        imm_ext_s = WIDTH'($signed(bus.i_Im));
`ifdef DATAPATH2_FWD_EN
        src_a_s   = haz_a_s ? result_s : rd0_s;
        reg_b_s   = haz_b_s ? result_s : rd1_s;
        ready_s   = 1'b1;
`else
        src_a_s   = rd0_s;
        reg_b_s   = rd1_s;
        ready_s   = !(bus.i_Valid && (haz_a_s || haz_b_s));
`endif
        src_b_s   = (bus.i_ALUSrc == ALUSRC_IMM) ? imm_ext_s : reg_b_s;
        issue_s   = bus.i_Valid && ready_s;
    end

    // EX register next state: capture on issue, otherwise drain to a bubble.
    always_comb begin
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_sub_d   = ex_sub_q;
        ex_wa_d    = ex_wa_q;
        ex_we_d    = ex_we_q;
        ex_valid_d = issue_s;
        if (issue_s) begin
            ex_a_d   = src_a_s;
            ex_b_d   = src_b_s;
            ex_sub_d = bus.i_AddSub;
            ex_wa_d  = bus.i_WA;
            ex_we_d  = bus.i_WE;
        end else begin
            ex_we_d  = 1'b0;
        end
    end

    // Result register next state: load on a valid EX op, hold otherwise.
    always_comb begin
        out_valid_d = ex_valid_q;
        if (ex_valid_q) begin
            alu_out_d = result_s;
            flags_d   = flags_s;
        end else begin
            alu_out_d = alu_out_q;
            flags_d   = flags_q;
        end
    end

    // Pipeline and output registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ex_valid_q  <= 1'b0;
            ex_a_q      <= {WIDTH{1'b0}};
            ex_b_q      <= {WIDTH{1'b0}};
            ex_sub_q    <= 1'b0;
            ex_wa_q     <= {AW{1'b0}};
            ex_we_q     <= 1'b0;
            out_valid_q <= 1'b0;
            alu_out_q   <= {WIDTH{1'b0}};
            flags_q     <= FLAGS_CLEAR;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_sub_q    <= ex_sub_d;
            ex_wa_q     <= ex_wa_d;
            ex_we_q     <= ex_we_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.o_Ready    = ready_s;
    assign bus.o_Valid    = out_valid_q;
    assign bus.o_ALUout   = alu_out_q;
    assign bus.o_Cout     = flags_q.cout;
    assign bus.o_Overflow = flags_q.overflow;
    assign bus.o_Zero     = flags_q.zero;

endmodule

// File: tb/tb_datapath2.sv
// Directed self-checking bench for datapath2: a 32-bit instance driven from a vector
// table plus back-to-back hazard/reset sequences, and an 8-bit instance for overflow.
module tb_datapath2;
    import datapath2_pkg::*;

`ifdef DATAPATH2_FWD_EN
    localparam int HAZ_STALL = 1'b0;
`else
    localparam int HAZ_STALL = 1'b1;
`endif

    typedef struct {
        logic        src;
        logic        sub;
        logic        we;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  wa;
        logic [15:0] im;
        logic [31:0] ea;
        logic        ec;
        logic        ev;
        logic        ez;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [34:0] cap_q[$];
    int          cap_cyc[$];
    vec_t        tbl[12];

    always #5 clk = ~clk;

    datapath2_if #(.WIDTH(32), .NREGS(32), .IMM_W(16)) b32 ();
    datapath2_if #(.WIDTH(8), .NREGS(4), .IMM_W(8)) b8 ();

    datapath2 #(.WIDTH(32), .NREGS(32), .IMM_W(16)) dut (.i_CLK(clk), .i_RST(rst), .bus(b32));
    datapath2 #(.WIDTH(8), .NREGS(4), .IMM_W(8)) dut8 (.i_CLK(clk), .i_RST(rst), .bus(b8));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b32.o_Valid) begin
            cap_q.push_back({b32.o_Cout, b32.o_Overflow, b32.o_Zero, b32.o_ALUout});
            cap_cyc.push_back(cyc);
        end
    end

    function automatic vec_t mkv(logic src, logic sub, logic we, logic [4:0] ra0, logic [4:0] ra1,
                                 logic [4:0] wa, logic [15:0] im, logic [31:0] ea,
                                 logic ec, logic ev, logic ez);
        vec_t v;
        v.src = src; v.sub = sub; v.we = we; v.ra0 = ra0; v.ra1 = ra1; v.wa = wa; v.im = im;
        v.ea = ea; v.ec = ec; v.ev = ev; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input vec_t v, output int stalls);
        b32.i_Valid = 1'b1; b32.i_ALUSrc = v.src; b32.i_AddSub = v.sub; b32.i_WE = v.we;
        b32.i_RA0 = v.ra0; b32.i_RA1 = v.ra1; b32.i_WA = v.wa; b32.i_Im = v.im;
        stalls = 0;
        #1;
        while (!b32.o_Ready && stalls < 3) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!b32.o_Ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout: o_Ready still 0 after %0d cycles, required 1", stalls);
        end
        @(posedge clk);
        @(negedge clk);
        b32.i_Valid = 1'b0;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int s;
        issue(v, s);
        chk({nm, "_stall"}, 35'(s), 35'(0));
        chk({nm, "_ex_valid"}, 35'(b32.o_Valid), 35'(0));
        @(negedge clk);
        chk({nm, "_valid"}, 35'(b32.o_Valid), 35'(1));
        chk({nm, "_result"}, {b32.o_Cout, b32.o_Overflow, b32.o_Zero, b32.o_ALUout},
            {v.ec, v.ev, v.ez, v.ea});
        @(negedge clk);
        chk({nm, "_hold"}, {b32.o_Valid, b32.o_ALUout}, {1'b0, v.ea});
    endtask

    task automatic pair_seq(input string nm, input vec_t a, input vec_t b, input int exp_stall);
        int s1, s2;
        cap_q.delete(); cap_cyc.delete();
        issue(a, s1);
        issue(b, s2);
        repeat (4) @(negedge clk);
        chk({nm, "_stall_a"}, 35'(s1), 35'(0));
        chk({nm, "_stall_b"}, 35'(s2), 35'(exp_stall));
        chk({nm, "_count"}, 35'(cap_q.size()), 35'(2));
        if (cap_q.size() == 2) begin
            chk({nm, "_res_a"}, cap_q[0], {a.ec, a.ev, a.ez, a.ea});
            chk({nm, "_res_b"}, cap_q[1], {b.ec, b.ev, b.ez, b.ea});
            chk({nm, "_spacing"}, 35'(cap_cyc[1] - cap_cyc[0]), 35'(1 + exp_stall));
        end
    endtask

    task automatic run8(input string nm, input logic src, input logic sub, input logic [1:0] ra0,
                        input logic [1:0] ra1, input logic [1:0] wa, input logic [7:0] im,
                        input logic [10:0] exp);
        b8.i_Valid = 1'b1; b8.i_ALUSrc = src; b8.i_AddSub = sub; b8.i_WE = 1'b1;
        b8.i_RA0 = ra0; b8.i_RA1 = ra1; b8.i_WA = wa; b8.i_Im = im;
        #1;
        chk({nm, "_ready"}, 35'(b8.o_Ready), 35'(1));
        @(posedge clk);
        @(negedge clk);
        b8.i_Valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 35'(b8.o_Valid), 35'(1));
        chk({nm, "_result"}, 35'({b8.o_Cout, b8.o_Overflow, b8.o_Zero, b8.o_ALUout}), 35'(exp));
        @(negedge clk);
    endtask

    initial begin
        b32.i_Valid = 1'b0; b32.i_ALUSrc = 1'b0; b32.i_AddSub = 1'b0; b32.i_WE = 1'b0;
        b32.i_RA0 = 5'd0; b32.i_RA1 = 5'd0; b32.i_WA = 5'd0; b32.i_Im = 16'd0;
        b8.i_Valid = 1'b0; b8.i_ALUSrc = 1'b0; b8.i_AddSub = 1'b0; b8.i_WE = 1'b0;
        b8.i_RA0 = 2'd0; b8.i_RA1 = 2'd0; b8.i_WA = 2'd0; b8.i_Im = 8'd0;

        // src, sub, we, ra0, ra1, wa, imm, expected result, cout, overflow, zero
        tbl[0]  = mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0,  5'd0, 5'd1,  16'h0005, 32'h00000005, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mkv(ALUSRC_IMM, OP_SUB, 1'b1, 5'd1,  5'd0, 5'd2,  16'h0007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mkv(ALUSRC_IMM, OP_SUB, 1'b1, 5'd1,  5'd0, 5'd3,  16'h0005, 32'h00000000, 1'b1, 1'b0, 1'b1);
        tbl[3]  = mkv(ALUSRC_REG, OP_ADD, 1'b1, 5'd1,  5'd2, 5'd4,  16'h0000, 32'h00000003, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mkv(ALUSRC_REG, OP_SUB, 1'b1, 5'd2,  5'd1, 5'd5,  16'h0000, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0,  5'd0, 5'd6,  16'h7FFF, 32'h00007FFF, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd6,  5'd0, 5'd6,  16'h8000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0,  5'd0, 5'd0,  16'h0009, 32'h00000009, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mkv(ALUSRC_REG, OP_ADD, 1'b1, 5'd0,  5'd0, 5'd9,  16'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mkv(ALUSRC_IMM, OP_ADD, 1'b0, 5'd1,  5'd0, 5'd10, 16'h0001, 32'h00000006, 1'b0, 1'b0, 1'b0);
        tbl[10] = mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd10, 5'd0, 5'd11, 16'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        tbl[11] = mkv(ALUSRC_IMM, OP_SUB, 1'b1, 5'd0,  5'd0, 5'd12, 16'h0001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        #12 rst = 1'b0;
        @(negedge clk);

        // 8-bit instance: expected = {cout, overflow, zero, result}
        run8("w8_7f",  ALUSRC_IMM, OP_ADD, 2'd0, 2'd0, 2'd1, 8'h7F, {3'b000, 8'h7F});
        run8("w8_ovf", ALUSRC_IMM, OP_ADD, 2'd1, 2'd0, 2'd1, 8'h01, {3'b010, 8'h80});
        run8("w8_neg", ALUSRC_IMM, OP_SUB, 2'd0, 2'd0, 2'd2, 8'h01, {3'b000, 8'hFF});
        run8("w8_dbl", ALUSRC_REG, OP_ADD, 2'd1, 2'd1, 2'd3, 8'h00, {3'b111, 8'h00});

        for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset asserted mid-cycle while outputs hold a nonzero value
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {b32.o_Valid, b32.o_Ready, b32.o_Cout, b32.o_Overflow, b32.o_Zero, b32.o_ALUout},
            {2'b01, 3'b000, 32'h0});
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            run_vec($sformatf("rd0_r%0d", r),
                    mkv(ALUSRC_IMM, OP_ADD, 1'b0, 5'(r), 5'd0, 5'd0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1));
            run_vec($sformatf("rd1_r%0d", r),
                    mkv(ALUSRC_REG, OP_ADD, 1'b0, 5'd0, 5'(r), 5'd0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1));
        end

        pair_seq("haz_a",
                 mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0, 5'd0, 5'd1, 16'h5, 32'h00000005, 1'b0, 1'b0, 1'b0),
                 mkv(ALUSRC_IMM, OP_SUB, 1'b1, 5'd1, 5'd0, 5'd2, 16'h7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0),
                 HAZ_STALL);
        pair_seq("r0_wr",
                 mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0, 5'd0, 5'd0, 16'h9, 32'h00000009, 1'b0, 1'b0, 1'b0),
                 mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0, 5'd0, 5'd3, 16'h3, 32'h00000003, 1'b0, 1'b0, 1'b0),
                 0);
        pair_seq("haz_both",
                 mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0, 5'd0, 5'd1, 16'h6, 32'h00000006, 1'b0, 1'b0, 1'b0),
                 mkv(ALUSRC_REG, OP_ADD, 1'b1, 5'd1, 5'd1, 5'd4, 16'h0, 32'h0000000C, 1'b0, 1'b0, 1'b0),
                 HAZ_STALL);
        pair_seq("imm_no_haz",
                 mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0, 5'd0, 5'd2, 16'h8, 32'h00000008, 1'b0, 1'b0, 1'b0),
                 mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0, 5'd2, 5'd5, 16'h1, 32'h00000001, 1'b0, 1'b0, 1'b0),
                 0);
        pair_seq("we0_no_haz",
                 mkv(ALUSRC_IMM, OP_ADD, 1'b0, 5'd0, 5'd0, 5'd6, 16'hA, 32'h0000000A, 1'b0, 1'b0, 1'b0),
                 mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd6, 5'd0, 5'd7, 16'h1, 32'h00000001, 1'b0, 1'b0, 1'b0),
                 0);

        // Reset during the EX cycle discards the in-flight write and result pulse
        begin
            int s;
            cap_q.delete(); cap_cyc.delete();
            issue(mkv(ALUSRC_IMM, OP_ADD, 1'b1, 5'd0, 5'd0, 5'd3, 16'h4, 32'h4, 1'b0, 1'b0, 1'b0), s);
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("ex_reset_no_pulse", 35'(cap_q.size()), 35'(0));
            chk("ex_reset_out", {b32.o_Valid, b32.o_ALUout}, {1'b0, 32'h0});
            run_vec("ex_reset_r3",
                    mkv(ALUSRC_IMM, OP_ADD, 1'b0, 5'd3, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath2.md
# datapath2

Parametrised, pipelined successor to the single-cycle register-file/add-sub datapath. Accepts one operation per cycle over a valid/ready handshake, reads two source registers, adds or subtracts a register or sign-extended immediate, writes back, and reports result plus flags two edges after issue. Hazard forwarding is compile-time selectable. It sits between the user-project control logic and the Caravel logic-analyser/wishbone glue.

## Interface
- WIDTH, 32: datapath and register width, minimum 4.
- NREGS, 32: register count, power of two, minimum 2; AW = $clog2(NREGS).
- IMM_W, 16: immediate width; IMM_W <= WIDTH.
- i_CLK  in  1  sole clock, rising edge.
- i_RST  in  1  reset, asynchronous, active-high.
- i_Valid  in  1  operation presented.
- o_Ready  out  1  datapath accepts this cycle.
- i_ALUSrc  in  1  0 = B from register RA1, 1 = B from sign-extended i_Im.
- i_AddSub  in  1  0 = A+B, 1 = A-B.
- i_WE  in  1  write result to WA.
- i_RA0, i_RA1, i_WA  in  AW  source and destination register addresses.
- i_Im  in  IMM_W  immediate, two's complement.
- o_Valid  out  1  one-cycle pulse; result and flags valid.
- o_ALUout  out  WIDTH  registered result.
- o_Cout, o_Overflow, o_Zero  out  1  registered carry-out, signed overflow, result==0.

## Operation
- Issue (transfer) = i_Valid && o_Ready. Issue cycle: regfile read combinationally; A, B, op, WA, WE captured into EX register; ex_valid set.
- EX cycle: ALU operates on EX operands. At its closing edge: o_ALUout/flags loaded, o_Valid=1, and regfile[WA] written if WE && WA!=0.
- Register 0 reads zero always; writes to it are discarded, but o_ALUout still shows the computed value.
- Arithmetic: Sub = A + ~B + 1. Cout = carry out of bit WIDTH-1 (Sub: 1 = no borrow). Overflow = sign(A)==sign(B') && sign(result)!=sign(A), B' = effective addend. Zero = (result == 0).
- Immediate: {{(WIDTH-IMM_W){i_Im[IMM_W-1]}}, i_Im}.
- Hazard: issuing op reads (RA0, or RA1 with ALUSrc=0) the nonzero WA of a valid EX op with WE=1.
- No downstream backpressure; o_Valid is not held.
- Idle cycles: o_Valid=0; o_ALUout and flags hold last value.

## Timing
- Reset (async assert, sync-safe deassert): all regfile entries, EX register, ex_valid, o_Valid, o_ALUout, flags = 0; o_Ready = 1.
- Latency: issue at edge k -> o_Valid high cycle after edge k+1 (two edges). Throughput one op/cycle without hazards.
- Write at edge k+1 visible to reads in cycle after k+1.
- Reset mid-operation: in-flight EX op discarded; no write, no o_Valid pulse.
- Simultaneous hazard on both sources: treated as a single hazard.

## Configuration
- DATAPATH2_FWD_EN defined: EX result forwarded combinationally to hazarding source operand(s); o_Ready constant 1.
- Undefined: on hazard o_Ready=0 for exactly one cycle; op re-presented and issued next cycle with written value. Results identical in either build; only cycle counts differ.

## Structure
- Package datapath2_pkg: ALUSRC_REG=0, ALUSRC_IMM=1, OP_ADD=0, OP_SUB=1, and flags struct {cout, overflow, zero}.
- Sub-module regfile_p (WIDTH, NREGS): async reset, one write port, two combinational read ports, r0 hardwired zero.
- ALU, sign extension, hazard/forward logic inline.

## Test plan
- Reset: assert i_RST mid-cycle -> o_ALUout=0, all flags 0, o_Valid=0, o_Ready=1; RA0/RA1 reads of every register return 0.
- R1 = R0 + imm 5, then back-to-back R2 = R1 - imm 7 -> o_ALUout 0x00000005 then 0xFFFFFFFE, Cout=0, Overflow=0; FWD_EN: o_Valid on consecutive cycles; without: o_Ready low one cycle, one idle slot.
- R1(5) - imm 5 -> o_ALUout 0, Zero=1, Cout=1, Overflow=0.
- WIDTH=8, IMM_W=8: R1 = R0 + imm 0x7F, then R1 + imm 0x01 -> o_ALUout 0x80, Overflow=1, Cout=0; R0 - imm 0x01 -> 0xFF, Cout=0.
- WA=0, R0 + imm 9 with WE=1 -> o_ALUout 9; next op reading R0 sees 0; no hazard stall.
- Issue R3 = R0 + imm 4, assert i_RST during EX cycle -> no o_Valid pulse, R3 reads 0 after reset.
